fft_frame_sequencer: RTL and testbench

Top-level frame controller for the FFT datapath. It detects a completed SPI frame and streams the frame's samples into the FFT core with a load strobe and sample index. It then kicks the core with a start pulse, gates capture of the core's output words into the output buffer, and holds a result-valid flag until the MCU-side consumer acknowledges. It sits between the SPI frame receiver, the input/output frame buffers and the FFT core, all in the `clk` domain.

---
 rtl/fft_frame_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fft_frame_sequencer: SPI frame -> FFT core load/start/capture sequencer  |
// | Optional WAIT watchdog: define FFT_SEQ_TIMEOUT_EN.  Revision: 1.0        |
// +--------------------------------------------------------------------------+
module fft_frame_sequencer #(
  parameter int N_IN           = 512,
  parameter int N_OUT          = 256,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_loaded,
  input  logic                     fft_processing,
  input  logic                     fft_done,
  input  logic                     out_ack,
  output logic                     load_en,
  output logic [$clog2(N_IN)-1:0]  sample_idx,
  output logic                     fft_start,
  output logic                     out_clr,
  output logic                     capture_en,
  output logic [$clog2(N_OUT)-1:0] out_idx,
  output logic                     out_valid,
  output logic                     seq_busy,
  output logic [15:0]              frames_done,
  output logic [7:0]               dropped,
  output logic                     timeout_err
);

  localparam int IDX_W = $clog2(N_IN);
  localparam int OUT_W = $clog2(N_OUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_READY = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               frame_loaded_q;
  logic               pending_q, pending_d;
  logic [IDX_W-1:0]   sample_idx_q, sample_idx_d;
  logic [OUT_W-1:0]   out_idx_q, out_idx_d;
  logic [15:0]        frames_done_q, frames_done_d;
  logic [7:0]         dropped_q, dropped_d;
  logic               fft_start_q, fft_start_d;
  logic               out_clr_q, out_clr_d;
  logic               out_valid_q, out_valid_d;
  logic               seq_busy_q, seq_busy_d;
  logic               timeout_err_q, timeout_err_d;
  logic               frame_evt;
  logic               take_frame;
  logic               tmo_hit;

  assign frame_evt = frame_loaded & ~frame_loaded_q;

`ifdef FFT_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Counter is zero outside WAIT, so it restarts on entry and on every strobe.
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == S_WAIT && !fft_done) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end

  assign tmo_hit = (state_q == S_WAIT) && !fft_done &&
                   (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign tmo_hit            = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    sample_idx_d  = sample_idx_q;
    out_idx_d     = out_idx_q;
    frames_done_d = frames_done_q;
    dropped_d     = dropped_q;
    fft_start_d   = 1'b0;
    out_clr_d     = 1'b0;
    out_valid_d   = 1'b0;
    timeout_err_d = timeout_err_q;
    load_en       = 1'b0;
    capture_en    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if ((frame_evt || pending_q) && !fft_processing) begin
          state_d   = S_LOAD;
          out_clr_d = 1'b1;
        end
      end
      S_LOAD: begin
        load_en = !fft_processing;
        if (load_en) begin
          if (sample_idx_q == IDX_W'(N_IN - 1)) begin
            sample_idx_d = '0;
            fft_start_d  = 1'b1;
            state_d      = S_START;
          end else begin
            sample_idx_d = sample_idx_q + IDX_W'(1);
          end
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        capture_en = fft_done;
        if (fft_done) begin
          if (out_idx_q == OUT_W'(N_OUT - 1)) begin
            out_idx_d     = '0;
            frames_done_d = frames_done_q + 16'd1;
            out_valid_d   = 1'b1;
            state_d       = S_READY;
          end else begin
            out_idx_d = out_idx_q + OUT_W'(1);
          end
        end else if (tmo_hit) begin
          timeout_err_d = 1'b1;
          out_clr_d     = 1'b1;
          out_idx_d     = '0;
          state_d       = S_IDLE;
        end
      end
      S_READY: begin
        if (out_ack) begin
          state_d = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A frame consumed straight out of IDLE never becomes pending; any other
    // arrival is parked, and a second arrival while one is parked is lost.
    take_frame = (state_q == S_IDLE) && (state_d == S_LOAD);
    if (frame_evt) begin
      if (pending_q) begin
        if (dropped_q != 8'hFF) begin
          dropped_d = dropped_q + 8'd1;
        end
      end else if (!take_frame) begin
        pending_d = 1'b1;
      end
    end
    if (take_frame) begin
      pending_d = 1'b0;
    end

    seq_busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      frame_loaded_q <= 1'b0;
      pending_q      <= 1'b0;
      sample_idx_q   <= '0;
      out_idx_q      <= '0;
      frames_done_q  <= '0;
      dropped_q      <= '0;
      fft_start_q    <= 1'b0;
      out_clr_q      <= 1'b0;
      out_valid_q    <= 1'b0;
      seq_busy_q     <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      frame_loaded_q <= frame_loaded;
      pending_q      <= pending_d;
      sample_idx_q   <= sample_idx_d;
      out_idx_q      <= out_idx_d;
      frames_done_q  <= frames_done_d;
      dropped_q      <= dropped_d;
      fft_start_q    <= fft_start_d;
      out_clr_q      <= out_clr_d;
      out_valid_q    <= out_valid_d;
      seq_busy_q     <= seq_busy_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign sample_idx  = sample_idx_q;
  assign out_idx     = out_idx_q;
  assign frames_done = frames_done_q;
  assign dropped     = dropped_q;
  assign fft_start   = fft_start_q;
  assign out_clr     = out_clr_q;
  assign out_valid   = out_valid_q;
  assign seq_busy    = seq_busy_q;
  assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fft_frame_sequencer: directed self-checking bench for the sequencer   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fft_frame_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_loaded;
  logic        fft_processing;
  logic        fft_done;
  logic        out_ack;
  logic        load_en;
  logic [8:0]  sample_idx;
  logic        fft_start;
  logic        out_clr;
  logic        capture_en;
  logic [7:0]  out_idx;
  logic        out_valid;
  logic        seq_busy;
  logic [15:0] frames_done;
  logic [7:0]  dropped;
  logic        timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic mon_clr = 1'b1;
  int   load_cnt, idx_err, exp_idx, start_cnt, cap_cnt, cap_err, exp_out, clr_cnt;

  fft_frame_sequencer #(
    .N_IN           (512),
    .N_OUT          (256),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .frame_loaded   (frame_loaded),
    .fft_processing (fft_processing),
    .fft_done       (fft_done),
    .out_ack        (out_ack),
    .load_en        (load_en),
    .sample_idx     (sample_idx),
    .fft_start      (fft_start),
    .out_clr        (out_clr),
    .capture_en     (capture_en),
    .out_idx        (out_idx),
    .out_valid      (out_valid),
    .seq_busy       (seq_busy),
    .frames_done    (frames_done),
    .dropped        (dropped),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  // Strobe monitor: counts per-frame events and checks index sequencing.
  always @(negedge clk) begin
    if (mon_clr) begin
      load_cnt  <= 0; idx_err <= 0; exp_idx <= 0; start_cnt <= 0;
      cap_cnt   <= 0; cap_err <= 0; exp_out <= 0; clr_cnt   <= 0;
    end else begin
      if (load_en) begin
        if (int'(sample_idx) != exp_idx) idx_err <= idx_err + 1;
        exp_idx  <= (exp_idx + 1) % 512;
        load_cnt <= load_cnt + 1;
      end
      if (capture_en) begin
        if (int'(out_idx) != exp_out) cap_err <= cap_err + 1;
        exp_out <= (exp_out + 1) % 256;
        cap_cnt <= cap_cnt + 1;
      end
      if (fft_start) start_cnt <= start_cnt + 1;
      if (out_clr)   clr_cnt   <= clr_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (fft_start !== 1'b1 && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) check_eq("start_wait_expired", 0, 1);
  endtask

  task automatic wait_idx(input logic [8:0] idx, output int n);
    n = 0;
    while (sample_idx !== idx && n < 1000) begin
      step();
      n++;
    end
    if (n >= 1000) check_eq("idx_wait_expired", 0, 1);
  endtask

  task automatic send_done(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      fft_done = 1'b1;
      step();
      fft_done = 1'b0;
      repeat (gap) step();
    end
  endtask

  task automatic new_frame();
    frame_loaded = 1'b1;
    step();
    frame_loaded = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n2;
    reset = 1'b1; frame_loaded = 1'b0; fft_processing = 1'b0;
    fft_done = 1'b0; out_ack = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    check_eq("rst_busy",   seq_busy,    0);
    check_eq("rst_idx",    sample_idx,  0);
    check_eq("rst_frames", frames_done, 0);
    check_eq("rst_valid",  out_valid,   0);
    check_eq("rst_load",   load_en,     0);
    step();
    mon_clr = 1'b0;

    // Basic frame; a strobe during START must be ignored.
    new_frame();
    check_eq("b_out_clr", out_clr,  1);
    check_eq("b_busy",    seq_busy, 1);
    wait_start(n);
    check_eq("b_load_cycles", n, 512);
    fft_done = 1'b1;
    #1;
    check_eq("b_cap_in_start", capture_en, 0);
    step();
    fft_done = 1'b0;
    check_eq("b_start_pulse", fft_start, 0);
    send_done(255, 1);
    check_eq("b_valid_early", out_valid, 0);
    send_done(1, 0);
    check_eq("b_valid",   out_valid,   1);
    check_eq("b_frames",  frames_done, 1);
    check_eq("b_out_idx", out_idx,     0);
    step();
    check_eq("b_valid_hold", out_valid, 1);
    check_eq("b_loads",   load_cnt,  512);
    check_eq("b_idx_seq", idx_err,   0);
    check_eq("b_starts",  start_cnt, 1);
    check_eq("b_caps",    cap_cnt,   256);
    check_eq("b_cap_seq", cap_err,   0);
    check_eq("b_clrs",    clr_cnt,   1);
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
    check_eq("b_ack_valid", out_valid, 0);
    check_eq("b_ack_busy",  seq_busy,  0);

    // Load stall of 3 cycles at sample 100.
    mon_clr = 1'b1; step(); mon_clr = 1'b0;
    new_frame();
    wait_idx(9'd100, n);
    fft_processing = 1'b1;
    #1;
    check_eq("s_load_low", load_en, 0);
    repeat (3) step();
    check_eq("s_idx_hold", sample_idx, 100);
    fft_processing = 1'b0;
    wait_start(n2);
    check_eq("s_load_cycles", n + 3 + n2, 515);
    check_eq("s_loads",   load_cnt, 512);
    check_eq("s_idx_seq", idx_err,  0);
    step();
    send_done(256, 0);
    check_eq("s_frames", frames_done, 2);
    out_ack = 1'b1; step(); out_ack = 1'b0;

    // Overrun: three frame edges while waiting on the core.
    new_frame();
    wait_start(n);
    step();
    for (int i = 0; i < 3; i++) begin
      frame_loaded = 1'b1; step();
      frame_loaded = 1'b0; step();
    end
    check_eq("o_dropped", dropped, 2);
    send_done(256, 0);
    check_eq("o_frames", frames_done, 3);
    out_ack = 1'b1; step(); out_ack = 1'b0;
    check_eq("o_idle", seq_busy, 0);
    step();
    check_eq("o_reload_busy", seq_busy, 1);
    check_eq("o_reload_clr",  out_clr,  1);

    // Reset in the middle of loading.
    wait_idx(9'd300, n);
    reset = 1'b1;
    step();
    check_eq("r_busy",    seq_busy,    0);
    check_eq("r_idx",     sample_idx,  0);
    check_eq("r_frames",  frames_done, 0);
    check_eq("r_dropped", dropped,     0);
    check_eq("r_load",    load_en,     0);
    reset = 1'b0;
    step();

    // out_ack coinciding with a frame edge in READY.
    new_frame();
    wait_start(n);
    step();
    send_done(256, 0);
    check_eq("a_valid", out_valid, 1);
    out_ack = 1'b1; frame_loaded = 1'b1;
    step();
    out_ack = 1'b0; frame_loaded = 1'b0;
    check_eq("a_idle",  seq_busy,  0);
    check_eq("a_valid_fall", out_valid, 0);
    step();
    check_eq("a_load_busy", seq_busy, 1);
    check_eq("a_load_clr",  out_clr,  1);
    check_eq("a_dropped",   dropped,  0);

    // Core stops after 10 words.
    wait_start(n);
    step();
    send_done(10, 0);
    repeat (15) step();
    check_eq("t_busy_pre", seq_busy,    1);
    check_eq("t_err_pre",  timeout_err, 0);
    step();
`ifdef FFT_SEQ_TIMEOUT_EN
    check_eq("t_idle",    seq_busy,    0);
    check_eq("t_err",     timeout_err, 1);
    check_eq("t_clr",     out_clr,     1);
    check_eq("t_out_idx", out_idx,     0);
    check_eq("t_frames",  frames_done, 1);
    step();
    check_eq("t_err_sticky", timeout_err, 1);
`else
    check_eq("t_busy",    seq_busy,    1);
    check_eq("t_err",     timeout_err, 0);
    check_eq("t_out_idx", out_idx,     10);
    check_eq("t_frames",  frames_done, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
